// File: rtl/syscall_responder.sv
// ---------------------------------------------------------------------------
// syscall_responder
//
// Services syscall requests coming from the CPU's syscall detect logic.
// A request carries a code (v0) and an argument (a0). Print requests are
// turned into an ASCII byte stream on a valid/ready console port. Exit sets
// a sticky halt. The CPU is stalled (busy) until the request retires.
//
// Supported codes:
//   1  print signed decimal integer (leading zeros suppressed)
//   10 exit: sticky halt, block stays in HALTED until reset
//   11 print character a0[7:0]
//   34 print 8 lowercase hex digits, leading zeros kept
//   any other code retires at once with an err_unknown pulse
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   req_valid_i     request present
//   req_ready_o     request can be accepted (IDLE only)
//   req_code_i      syscall code (v0)
//   req_arg_i       syscall argument (a0)
//   busy_o          CPU stall, high in every state except IDLE
//   done_o          one-cycle pulse when a request retires
//   err_unknown_o   one-cycle pulse with done_o for an unsupported code
//   halt_o          sticky exit flag, cleared only by reset
//   tx_valid_o      console byte valid
//   tx_data_o       console ASCII byte
//   tx_ready_i      console sink accepts the byte
//   syscall_count_o number of accepted requests, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module syscall_responder #(
  parameter int unsigned CNT_W      = 32,
  parameter bit          NEWLINE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_code_i,
  input  logic [31:0]      req_arg_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_unknown_o,
  output logic             halt_o,
  output logic             tx_valid_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_ready_i,
  output logic [CNT_W-1:0] syscall_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    EMIT,
    DONE,
    HALTED
  } state_e;

  localparam logic [31:0] CODE_INT  = 32'd1;
  localparam logic [31:0] CODE_EXIT = 32'd10;
  localparam logic [31:0] CODE_CHAR = 32'd11;
  localparam logic [31:0] CODE_HEX  = 32'd34;

  state_e           state_q, state_d;
  logic [31:0]      code_q, code_d;
  logic [31:0]      arg_q, arg_d;
  logic [31:0]      bin_q, bin_d;
  logic [39:0]      bcd_q, bcd_d;
  logic [4:0]       step_q, step_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       start_q, start_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [39:0]      bcdAdj;
  logic [39:0]      bcdShift;
  logic [3:0]       leadIdx;
  logic             isNeg;
  logic             isUnknown;
  logic [3:0]       lastIdx;
  logic [4:0]       hexShift;
  logic [3:0]       decIdx;
  logic [5:0]       decShift;
  logic [7:0]       emitByte;

  function automatic logic [7:0] hexAscii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};
  endfunction

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift the
  // whole BCD field left by one, pulling in the next magnitude bit (MSB first).
  // The leading-digit index is derived from the shifted result so that on the
  // final step it is ready for the CONV->EMIT edge at no extra cycle cost.
  // Byte index layout for code 1: 0 = '-', 1..10 = digits MS..LS, 11 = newline.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcdAdj[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcdAdj[4*i +: 4] + 4'd3;
      end
    end
    bcdShift = (bcdAdj << 1) | {39'b0, bin_q[31]};
    leadIdx  = 4'd10;
    for (int d = 0; d < 10; d++) begin
      if (bcdShift[4*d +: 4] != 4'd0) begin
        leadIdx = 4'(10 - d);
      end
    end
  end

  // Request classification and the index of the final byte for each format.
  always_comb begin
    isNeg     = (code_q == CODE_INT) && arg_q[31];
    isUnknown = (code_q != CODE_INT) && (code_q != CODE_CHAR) &&
                (code_q != CODE_HEX) && (code_q != CODE_EXIT);
    if (code_q == CODE_CHAR) begin
      lastIdx = 4'd0;
    end else if (code_q == CODE_HEX) begin
      lastIdx = NEWLINE_EN ? 4'd8 : 4'd7;
    end else begin
      lastIdx = NEWLINE_EN ? 4'd11 : 4'd10;
    end
  end

  // Byte currently presented on the console, selected purely from registered
  // state so it holds steady while the sink stalls. Shift amounts are clamped
  // to in-range values for indices that do not select a digit.
  always_comb begin
    hexShift = {~idx_q[2:0], 2'b00};
    decIdx   = ((idx_q >= 4'd1) && (idx_q <= 4'd10)) ? (4'd10 - idx_q) : 4'd0;
    decShift = {decIdx, 2'b00};
    emitByte = 8'h0A;
    if (code_q == CODE_CHAR) begin
      emitByte = arg_q[7:0];
    end else if (code_q == CODE_HEX) begin
      if (idx_q < 4'd8) begin
        emitByte = hexAscii(arg_q[hexShift +: 4]);
      end
    end else begin
      if (idx_q == 4'd0) begin
        emitByte = 8'h2D;
      end else if (idx_q <= 4'd10) begin
        emitByte = 8'h30 + {4'h0, bcd_q[decShift +: 4]};
      end
    end
  end

  // Next-state logic. The magnitude is taken on accept as 32-bit unsigned,
  // so the most negative argument converts to 2147483648. After the '-' the
  // index jumps straight to the first significant digit.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    arg_d   = arg_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    idx_d   = idx_q;
    start_d = start_q;
    halt_d  = halt_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          code_d  = req_code_i;
          arg_d   = req_arg_i;
          bin_d   = req_arg_i[31] ? (~req_arg_i + 32'd1) : req_arg_i;
          bcd_d   = '0;
          step_d  = '0;
          idx_d   = '0;
          count_d = count_q + CNT_W'(1);
          if (req_code_i == CODE_INT) begin
            state_d = CONV;
          end else if ((req_code_i == CODE_CHAR) || (req_code_i == CODE_HEX)) begin
            state_d = EMIT;
          end else if (req_code_i == CODE_EXIT) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      CONV: begin
        bcd_d  = bcdShift;
        bin_d  = {bin_q[30:0], 1'b0};
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) begin
          state_d = EMIT;
          start_d = leadIdx;
          idx_d   = isNeg ? 4'd0 : leadIdx;
        end
      end
      EMIT: begin
        if (tx_ready_i) begin
          if (idx_q == lastIdx) begin
            state_d = DONE;
          end else if (isNeg && (idx_q == 4'd0)) begin
            idx_d = start_q;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any request in flight and drops its output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      arg_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      start_q <= '0;
      halt_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      arg_q   <= arg_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      halt_q  <= halt_d;
      count_q <= count_d;
    end
  end

  // Outputs are decoded from the state so they track reset immediately.
  always_comb begin
    req_ready_o     = (state_q == IDLE);
    busy_o          = (state_q != IDLE);
    done_o          = (state_q == DONE);
    err_unknown_o   = (state_q == DONE) && isUnknown;
    halt_o          = halt_q;
    tx_valid_o      = (state_q == EMIT);
    tx_data_o       = (state_q == EMIT) ? emitByte : 8'h00;
    syscall_count_o = count_q;
  end

endmodule
